// File: rtl/oled_pkg.sv
// Shared constants for the SSD1306 command sequencer.
//   - SSD1306 control bytes (command / GDDRAM data)
//   - SSD1306 opcodes referenced by name in the sequencer and the init ROM
//   - Sequencer state encoding
package oled_pkg;

    // Control byte that precedes every payload byte on the I2C link
    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;

    // SSD1306 opcodes
    localparam logic [7:0] DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] PAGE_BASE   = 8'hB0;

    // Sequencer states
    localparam logic [2:0] ST_PWRUP      = 3'd0;
    localparam logic [2:0] ST_INIT_ISSUE = 3'd1;
    localparam logic [2:0] ST_INIT_WAIT  = 3'd2;
    localparam logic [2:0] ST_CLR_ISSUE  = 3'd3;
    localparam logic [2:0] ST_CLR_WAIT   = 3'd4;
    localparam logic [2:0] ST_READY      = 3'd5;
    localparam logic [2:0] ST_USR_WAIT   = 3'd6;

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 power-on command list, indexed combinationally.
//   idx  in  5  entry index (0..24 valid)
//   cmd  out 8  command byte; 8'h00 for indices beyond the list
module oled_init_rom
    import oled_pkg::*;
(
    input  logic [4:0] idx,
    output logic [7:0] cmd
);

    always_comb begin
        cmd = 8'h00;
        unique case (idx)
            5'd0:  cmd = DISPLAY_OFF;
            5'd1:  cmd = 8'hD5;  // clock divide
            5'd2:  cmd = 8'h80;
            5'd3:  cmd = 8'hA8;  // multiplex ratio
            5'd4:  cmd = 8'h3F;
            5'd5:  cmd = 8'hD3;  // display offset
            5'd6:  cmd = 8'h00;
            5'd7:  cmd = 8'h40;  // start line 0
            5'd8:  cmd = 8'h8D;  // charge pump
            5'd9:  cmd = 8'h14;
            5'd10: cmd = 8'h20;  // addressing mode: page
            5'd11: cmd = 8'h02;
            5'd12: cmd = 8'hA1;  // segment remap
            5'd13: cmd = 8'hC8;  // COM scan direction
            5'd14: cmd = 8'hDA;  // COM pins
            5'd15: cmd = 8'h12;
            5'd16: cmd = 8'h81;  // contrast
            5'd17: cmd = 8'hCF;
            5'd18: cmd = 8'hD9;  // precharge
            5'd19: cmd = 8'hF1;
            5'd20: cmd = 8'hDB;  // VCOMH
            5'd21: cmd = 8'h40;
            5'd22: cmd = 8'hA4;  // resume from RAM
            5'd23: cmd = 8'hA6;  // normal (non-inverted)
            5'd24: cmd = DISPLAY_ON;
            default: cmd = 8'h00;
        endcase
    end

endmodule

// File: rtl/oled_cmd_seq.sv
// SSD1306 command sequencer in front of the I2C byte-write driver.
// Waits PWRUP_CYCLES after reset, sends the init ROM, optionally clears GDDRAM,
// then forwards user bytes from a valid/ready port. One byte per driver transaction.
// Build option: define OLED_CLEAR_EN to include the full-screen clear after init.
// Ports:
//   i2c_clk, rst_n         clock from the driver, async active-low reset
//   exec                   one-cycle transaction start pulse
//   we, addr_hl            driver controls, tied 1 / 0
//   word_addr[15:0]        {8'h00, control byte}
//   wdata[7:0]             command or data byte
//   done                   one-cycle transaction-complete pulse
//   wr_valid/wr_ready      user byte handshake
//   wr_is_data, wr_byte    user byte kind and value
//   init_done              sticky once init (and clear) has finished
module oled_cmd_seq
    import oled_pkg::*;
#(
    parameter int unsigned PWRUP_CYCLES = 100000,
    parameter int unsigned INIT_LEN     = 25
) (
    input  logic        i2c_clk,
    input  logic        rst_n,
    output logic        exec,
    output logic        we,
    output logic        addr_hl,
    output logic [15:0] word_addr,
    output logic [7:0]  wdata,
    input  logic        done,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic        wr_is_data,
    input  logic [7:0]  wr_byte,
    output logic        init_done
);

    logic [2:0]  state_q, state_d;
    logic [31:0] pwr_cnt_q, pwr_cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic        exec_q, exec_d;
    logic [15:0] word_addr_q, word_addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wr_ready_q, wr_ready_d;
    logic        init_done_q, init_done_d;
    logic [7:0]  rom_cmd;

`ifdef OLED_CLEAR_EN
    logic [2:0] page_q, page_d;
    logic [6:0] col_q, col_d;
    // 0: page select, 1: column low, 2: column high, 3: data bytes
    logic [1:0] phase_q, phase_d;
`endif

    oled_init_rom u_rom (
        .idx (idx_q),
        .cmd (rom_cmd)
    );

    always_comb begin
        state_d     = state_q;
        pwr_cnt_d   = pwr_cnt_q;
        idx_d       = idx_q;
        exec_d      = 1'b0;
        word_addr_d = word_addr_q;
        wdata_d     = wdata_q;
        wr_ready_d  = 1'b0;
        init_done_d = init_done_q;
`ifdef OLED_CLEAR_EN
        page_d      = page_q;
        col_d       = col_q;
        phase_d     = phase_q;
`endif
        unique case (state_q)
            ST_PWRUP: begin
                if (pwr_cnt_q == PWRUP_CYCLES - 1) begin
                    state_d = ST_INIT_ISSUE;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 32'd1;
                end
            end
            ST_INIT_ISSUE: begin
                wdata_d     = rom_cmd;
                word_addr_d = {8'h00, CTRL_CMD};
                exec_d      = 1'b1;
                state_d     = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (done) begin
                    // idx stops at the last entry so it never indexes past the list
                    if (idx_q == 5'(INIT_LEN - 1)) begin
`ifdef OLED_CLEAR_EN
                        state_d     = ST_CLR_ISSUE;
`else
                        state_d     = ST_READY;
                        init_done_d = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = ST_INIT_ISSUE;
                    end
                end
            end
`ifdef OLED_CLEAR_EN
            ST_CLR_ISSUE: begin
                exec_d  = 1'b1;
                state_d = ST_CLR_WAIT;
                unique case (phase_q)
                    2'd0: begin
                        word_addr_d = {8'h00, CTRL_CMD};
                        wdata_d     = PAGE_BASE + {5'b0, page_q};
                    end
                    2'd1: begin
                        word_addr_d = {8'h00, CTRL_CMD};
                        wdata_d     = 8'h00;
                    end
                    2'd2: begin
                        word_addr_d = {8'h00, CTRL_CMD};
                        wdata_d     = 8'h10;
                    end
                    default: begin
                        word_addr_d = {8'h00, CTRL_DATA};
                        wdata_d     = 8'h00;
                    end
                endcase
            end
            ST_CLR_WAIT: begin
                if (done) begin
                    state_d = ST_CLR_ISSUE;
                    if (phase_q != 2'd3) begin
                        phase_d = phase_q + 2'd1;
                    end else begin
                        col_d = col_q + 7'd1;  // wraps 127 -> 0
                        if (col_q == 7'd127) begin
                            phase_d = 2'd0;
                            if (page_q == 3'd7) begin
                                state_d     = ST_READY;
                                init_done_d = 1'b1;
                            end else begin
                                page_d = page_q + 3'd1;
                            end
                        end
                    end
                end
            end
`endif
            ST_READY: begin
                if (wr_ready_q && wr_valid) begin
                    wdata_d     = wr_byte;
                    word_addr_d = {8'h00, wr_is_data ? CTRL_DATA : CTRL_CMD};
                    exec_d      = 1'b1;
                    state_d     = ST_USR_WAIT;
                end else begin
                    wr_ready_d = 1'b1;
                end
            end
            ST_USR_WAIT: begin
                if (done) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_PWRUP;
        endcase
    end

    always_ff @(posedge i2c_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PWRUP;
            pwr_cnt_q   <= 32'd0;
            idx_q       <= 5'd0;
            exec_q      <= 1'b0;
            word_addr_q <= 16'h0000;
            wdata_q     <= 8'h00;
            wr_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
`ifdef OLED_CLEAR_EN
            page_q      <= 3'd0;
            col_q       <= 7'd0;
            phase_q     <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            pwr_cnt_q   <= pwr_cnt_d;
            idx_q       <= idx_d;
            exec_q      <= exec_d;
            word_addr_q <= word_addr_d;
            wdata_q     <= wdata_d;
            wr_ready_q  <= wr_ready_d;
            init_done_q <= init_done_d;
`ifdef OLED_CLEAR_EN
            page_q      <= page_d;
            col_q       <= col_d;
            phase_q     <= phase_d;
`endif
        end
    end

    assign exec      = exec_q;
    assign we        = 1'b1;
    assign addr_hl   = 1'b0;
    assign word_addr = word_addr_q;
    assign wdata     = wdata_q;
    assign wr_ready  = wr_ready_q;
    assign init_done = init_done_q;

endmodule
